// File: rtl/nv_nvdla_sdp_x2_op_pkg.sv
// Shared encodings for the SDP X2 operand unpacker: operand modes, FSM states, lane width.
package nv_nvdla_sdp_x2_op_pkg;

    localparam int LANE_W = 16;

    // Mode bit 0 = ALU operands present, bit 1 = MUL operands present.
    localparam logic [1:0] MODE_NONE       = 2'd0;
    localparam logic [1:0] MODE_SINGLE_ALU = 2'd1;
    localparam logic [1:0] MODE_SINGLE_MUL = 2'd2;
    localparam logic [1:0] MODE_PAIR       = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic [1:0] cfg_to_mode(input logic alu_en, input logic mul_en);
        return {mul_en, alu_en};
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_x2_op_perf.sv
// Saturating 32-bit stall counter for the X2 operand unpacker (built only with NVDLA_SDP_X2_OP_PERF_EN).
module nv_nvdla_sdp_x2_op_perf (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] stall_cnt
);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt <= 32'd0;
        end else if (clr) begin
            stall_cnt <= 32'd0;
        end else if (inc && (stall_cnt != 32'hffff_ffff)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_x2_op_unpack.sv
// Splits X2 operand DMA words into independent ALU / MUL operand streams and counts beats per layer.
// Optional stall counter enabled by defining NVDLA_SDP_X2_OP_PERF_EN.
//
// state | meaning
// IDLE  | waiting for op_en; no input accepted
// RUN   | unpacking words until the beat after count == cfg_beat_num is accepted
module nv_nvdla_sdp_x2_op_unpack
    import nv_nvdla_sdp_x2_op_pkg::*;
#(
    parameter int THROUGHPUT = 2,
    parameter int CNT_W      = 24
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rstn,
    input  logic                         op_en,
    input  logic                         cfg_alu_en,
    input  logic                         cfg_mul_en,
    input  logic [CNT_W-1:0]             cfg_beat_num,
    input  logic [32*THROUGHPUT-1:0]     dma_rd_pd,
    input  logic                         dma_rd_pvld,
    output logic                         dma_rd_prdy,
    output logic [16*THROUGHPUT-1:0]     chn_alu_op,
    output logic                         chn_alu_op_pvld,
    input  logic                         chn_alu_op_prdy,
    output logic [16*THROUGHPUT-1:0]     chn_mul_op,
    output logic                         chn_mul_op_pvld,
    input  logic                         chn_mul_op_prdy,
    output logic                         op_done
`ifdef NVDLA_SDP_X2_OP_PERF_EN
    ,
    output logic [31:0]                  perf_stall_cnt
`endif
);

    localparam int BEAT_W = LANE_W * THROUGHPUT;
    localparam int WORD_W = 2 * BEAT_W;

    logic [0:0]        state;
    logic [1:0]        mode_r;
    logic [CNT_W-1:0]  beat_num_r;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] hold_pd;
    logic              hold_vld;
    logic              half;
    logic              alu_taken;
    logic              mul_taken;

    logic              st_run;
    logic              mode_pair;
    logic [1:0]        start_mode;
    logic              op_start;
    logic              alu_acc;
    logic              mul_acc;
    logic              pair_done;
    logic              beat_acc;
    logic              last_beat;
    logic              hold_release;
    logic              rd_acc;
    logic [BEAT_W-1:0] pair_alu;
    logic [BEAT_W-1:0] pair_mul;
    logic [BEAT_W-1:0] single_beat;

    assign st_run     = (state == ST_RUN);
    assign mode_pair  = (mode_r == MODE_PAIR);
    assign start_mode = cfg_to_mode(cfg_alu_en, cfg_mul_en);
    assign op_start   = op_en & ~st_run;

    // In PAIR each stream drops its pvld once taken; in SINGLE only the enabled stream ever asserts.
    assign chn_alu_op_pvld = hold_vld & mode_r[0] & (~mode_pair | ~alu_taken);
    assign chn_mul_op_pvld = hold_vld & mode_r[1] & (~mode_pair | ~mul_taken);

    assign alu_acc   = chn_alu_op_pvld & chn_alu_op_prdy;
    assign mul_acc   = chn_mul_op_pvld & chn_mul_op_prdy;
    assign pair_done = hold_vld & (alu_taken | alu_acc) & (mul_taken | mul_acc);
    assign beat_acc  = mode_pair ? pair_done : (alu_acc | mul_acc);
    assign last_beat = beat_acc & (cnt == beat_num_r);

    // A last beat on half 0 also releases the word, discarding the unused high half.
    assign hold_release = mode_pair ? pair_done : (beat_acc & (half | last_beat));
    assign dma_rd_prdy  = st_run & (~hold_vld | hold_release) & ~last_beat;
    assign rd_acc       = dma_rd_pvld & dma_rd_prdy;

    always_comb begin
        pair_alu = '0;
        pair_mul = '0;
        for (int i = 0; i < THROUGHPUT; i++) begin
            pair_alu[i*LANE_W +: LANE_W] = hold_pd[(2*i)*LANE_W +: LANE_W];
            pair_mul[i*LANE_W +: LANE_W] = hold_pd[(2*i+1)*LANE_W +: LANE_W];
        end
    end

    assign single_beat = half ? hold_pd[WORD_W-1:BEAT_W] : hold_pd[BEAT_W-1:0];
    assign chn_alu_op  = mode_pair ? pair_alu : single_beat;
    assign chn_mul_op  = mode_pair ? pair_mul : single_beat;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state      <= ST_IDLE;
            mode_r     <= MODE_NONE;
            beat_num_r <= '0;
            cnt        <= '0;
            op_done    <= 1'b0;
        end else begin
            op_done <= 1'b0;
            if (op_start) begin
                mode_r     <= start_mode;
                beat_num_r <= cfg_beat_num;
                cnt        <= '0;
                if (start_mode == MODE_NONE) begin
                    op_done <= 1'b1;
                end else begin
                    state <= ST_RUN;
                end
            end else if (st_run && beat_acc) begin
                cnt <= cnt + CNT_W'(1);
                if (last_beat) begin
                    state   <= ST_IDLE;
                    op_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            hold_pd   <= '0;
            hold_vld  <= 1'b0;
            half      <= 1'b0;
            alu_taken <= 1'b0;
            mul_taken <= 1'b0;
        end else if (rd_acc) begin
            hold_pd   <= dma_rd_pd;
            hold_vld  <= 1'b1;
            half      <= 1'b0;
            alu_taken <= 1'b0;
            mul_taken <= 1'b0;
        end else if (hold_release) begin
            hold_vld  <= 1'b0;
            half      <= 1'b0;
            alu_taken <= 1'b0;
            mul_taken <= 1'b0;
        end else begin
            if (!mode_pair && beat_acc) begin
                half <= 1'b1;
            end
            if (mode_pair) begin
                alu_taken <= alu_taken | alu_acc;
                mul_taken <= mul_taken | mul_acc;
            end
        end
    end

`ifdef NVDLA_SDP_X2_OP_PERF_EN
    logic stall;

    assign stall = st_run & ((chn_alu_op_pvld & ~chn_alu_op_prdy) |
                             (chn_mul_op_pvld & ~chn_mul_op_prdy) |
                             (~hold_vld & ~dma_rd_pvld));

    nv_nvdla_sdp_x2_op_perf u_perf (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .clr             (op_start),
        .inc             (stall),
        .stall_cnt       (perf_stall_cnt)
    );
`endif

endmodule
